// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle unsigned subtractor, diff = a - b, CHUNK bits per clock, LSB chunk first.
// Define CHUNKED_SUB_OVF_EN to add the signed-overflow output ovf.
module chunked_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef CHUNKED_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   step;

  // One slice of the borrow chain; the extra top bit is the borrow out of this chunk.
  assign step = {1'b0, a_r[int'(cnt)*CHUNK +: CHUNK]}
              - {1'b0, b_r[int'(cnt)*CHUNK +: CHUNK]}
              - {{CHUNK{1'b0}}, borrow_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      diff_r    <= '0;
      borrow_r  <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          diff_r[int'(cnt)*CHUNK +: CHUNK] <= step[CHUNK-1:0];
          borrow_r                         <= step[CHUNK];
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Result registers are left untouched so they remain visible after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign diff   = diff_r;
  assign borrow = borrow_r;
  assign zero   = ~|diff_r;

`ifdef CHUNKED_SUB_OVF_EN
  assign ovf = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_r[WIDTH-1] != a_r[WIDTH-1]);
`endif

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed and swept checks of chunked_subtractor; main instance is WIDTH=16, CHUNK=4.
// Three further instances cover CHUNK=1, CHUNK=WIDTH and WIDTH=32/CHUNK=8.
`timescale 1ns/1ps
module tb_chunked_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;
  logic        zero;
`ifdef CHUNKED_SUB_OVF_EN
  logic        ovf;
  logic        sw_ovf[3];
`endif

  int checks = 0;
  int errors = 0;

  logic        sw_iv[3];
  logic        sw_ir[3];
  logic        sw_ov[3];
  logic        sw_or[3];
  logic        sw_bo[3];
  logic        sw_z[3];
  logic [31:0] sw_a[3];
  logic [31:0] sw_b[3];
  logic [31:0] sw_d[3];
  logic [15:0] d0;
  logic [15:0] d1;
  logic [31:0] d2;

  chunked_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero)
`ifdef CHUNKED_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  chunked_subtractor #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]),
    .a(sw_a[0][15:0]), .b(sw_b[0][15:0]), .out_valid(sw_ov[0]), .out_ready(sw_or[0]),
    .diff(d0), .borrow(sw_bo[0]), .zero(sw_z[0])
`ifdef CHUNKED_SUB_OVF_EN
    , .ovf(sw_ovf[0])
`endif
  );

  chunked_subtractor #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]),
    .a(sw_a[1][15:0]), .b(sw_b[1][15:0]), .out_valid(sw_ov[1]), .out_ready(sw_or[1]),
    .diff(d1), .borrow(sw_bo[1]), .zero(sw_z[1])
`ifdef CHUNKED_SUB_OVF_EN
    , .ovf(sw_ovf[1])
`endif
  );

  chunked_subtractor #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]),
    .a(sw_a[2]), .b(sw_b[2]), .out_valid(sw_ov[2]), .out_ready(sw_or[2]),
    .diff(d2), .borrow(sw_bo[2]), .zero(sw_z[2])
`ifdef CHUNKED_SUB_OVF_EN
    , .ovf(sw_ovf[2])
`endif
  );

  assign sw_d[0] = {16'h0, d0};
  assign sw_d[1] = {16'h0, d1};
  assign sw_d[2] = d2;

  // Called at a falling edge; presents one operand pair and returns at the falling edge after accept.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0 || borrow !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_values: out_valid=%b diff=%h borrow=%b zero=%b, expected 0 0000 0 1",
               out_valid, diff, borrow, zero);
    end
`ifdef CHUNKED_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    start_op(16'h1234, 16'h0234);
    wait_out(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected 4", lat);
    end
    checks++;
    if (diff !== 16'h1000 || borrow !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: diff=%h borrow=%b zero=%b, expected 1000 0 0", diff, borrow, zero);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h1000) begin
      errors++;
      $display("[TB] FAIL basic_after_handshake: in_ready=%b out_valid=%b diff=%h, expected 1 0 1000",
               in_ready, out_valid, diff);
    end
  endtask

  task automatic test_borrow_ripple();
    int lat;
    out_ready = 1'b1;
    start_op(16'h0000, 16'h0001);
    wait_out(lat);
    checks++;
    if (lat != 4 || diff !== 16'hFFFF || borrow !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ripple_result: lat=%0d diff=%h borrow=%b zero=%b, expected 4 ffff 1 0",
               lat, diff, borrow, zero);
    end
    @(negedge clk);
    start_op(16'hABCD, 16'hABCD);
    wait_out(lat);
    checks++;
    if (lat != 4 || diff !== 16'h0000 || borrow !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL equal_result: lat=%0d diff=%h borrow=%b zero=%b, expected 4 0000 0 1",
               lat, diff, borrow, zero);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_op(16'h00F0, 16'h000F);
    wait_out(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (diff !== 16'h00E1 || in_ready !== 1'b0 || out_valid !== 1'b1 || borrow !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: diff=%h in_ready=%b out_valid=%b borrow=%b, expected 00e1 0 1 0",
                 i, diff, in_ready, out_valid, borrow);
      end
      a        = 16'hFFFF;
      b        = 16'h0000;
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (diff !== 16'h00E1 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ignored_input: diff=%h out_valid=%b, expected 00e1 1", diff, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 16'h00E1) begin
      errors++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b diff=%h, expected 0 1 00e1",
               out_valid, in_ready, diff);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    start_op(16'h1234, 16'h0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 16'h0 || borrow !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_values: out_valid=%b diff=%h borrow=%b zero=%b, expected 0 0000 0 1",
               out_valid, diff, borrow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_ready: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    start_op(16'h0005, 16'h0003);
    wait_out(lat);
    checks++;
    if (lat != 4 || diff !== 16'h0002 || borrow !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_newop: lat=%0d diff=%h borrow=%b zero=%b, expected 4 0002 0 0",
               lat, diff, borrow, zero);
    end
    @(negedge clk);
  endtask

`ifdef CHUNKED_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    logic [15:0] va[3];
    logic [15:0] vb[3];
    logic [15:0] vd[3];
    logic        vo[3];
    logic        vbo[3];
    va = '{16'h8000, 16'h7FFF, 16'h0005};
    vb = '{16'h0001, 16'hFFFF, 16'h0003};
    vd = '{16'h7FFF, 16'h8000, 16'h0002};
    vo = '{1'b1, 1'b1, 1'b0};
    vbo = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_out(lat);
      checks++;
      if (diff !== vd[i] || ovf !== vo[i] || borrow !== vbo[i]) begin
        errors++;
        $display("[TB] FAIL ovf_case%0d: diff=%h ovf=%b borrow=%b, expected %h %b %b",
                 i, diff, ovf, borrow, vd[i], vo[i], vbo[i]);
      end
      @(negedge clk);
    end
  endtask
`endif

  // Back-to-back random ops on one sweep instance with out_ready held high.
  task automatic test_sweep(input int sel, input int width, input int n);
    logic [31:0] mask;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
    int lat;
    mask = (width == 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    sw_or[sel] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ea = $urandom & mask;
      eb = $urandom & mask;
      if (i == 0) begin
        ea = 32'h0;
        eb = mask;
      end
      if (i == 1) begin
        ea = mask;
        eb = mask;
      end
      ed = (ea - eb) & mask;
      sw_a[sel]  = ea;
      sw_b[sel]  = eb;
      sw_iv[sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sw_iv[sel] = 1'b0;
      lat = 0;
      while (sw_ov[sel] !== 1'b1 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != n) begin
        errors++;
        $display("[TB] FAIL sweep%0d_latency op %0d: got %0d expected %0d", sel, i, lat, n);
      end
      checks++;
      if (sw_d[sel] !== ed || sw_bo[sel] !== (ea < eb) || sw_z[sel] !== (ed == 32'h0)) begin
        errors++;
        $display("[TB] FAIL sweep%0d_result %h-%h: diff=%h borrow=%b zero=%b, expected %h %b %b",
                 sel, ea, eb, sw_d[sel], sw_bo[sel], sw_z[sel], ed, (ea < eb), (ed == 32'h0));
      end
      @(negedge clk);
      checks++;
      if (sw_ir[sel] !== 1'b1 || sw_ov[sel] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep%0d_interval op %0d: in_ready=%b out_valid=%b, expected 1 0",
                 sel, i, sw_ir[sel], sw_ov[sel]);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    for (int i = 0; i < 3; i++) begin
      sw_iv[i] = 1'b0;
      sw_or[i] = 1'b0;
      sw_a[i]  = 32'h0;
      sw_b[i]  = 32'h0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_backpressure();
    test_reset_mid();
`ifdef CHUNKED_SUB_OVF_EN
    test_ovf();
`endif
    test_sweep(0, 16, 16);
    test_sweep(1, 16, 1);
    test_sweep(2, 32, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
